// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared state encoding and defaults for the UART frame parser
// Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_LEN_DEFAULT   = 16;

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
// uart_frame_parser_if : byte-strobe input, valid/ready payload output, errors
// Rev 1.0
// ============================================================================
interface uart_frame_parser_if;

  logic       i_RX_Done;
  logic [7:0] i_RX_Byte;
  logic [7:0] o_Data;
  logic       o_Data_Valid;
  logic       i_Data_Ready;
  logic       o_Data_Last;
  logic       o_Busy;
  logic       o_Err_Length;
  logic       o_Err_Checksum;
  logic       o_Err_Timeout;
  logic       o_Err_Overrun;

  // slave = the parser, master = the surrounding receiver and consumer
  modport slave (
    input  i_RX_Done, i_RX_Byte, i_Data_Ready,
    output o_Data, o_Data_Valid, o_Data_Last, o_Busy,
           o_Err_Length, o_Err_Checksum, o_Err_Timeout, o_Err_Overrun
  );

  modport master (
    output i_RX_Done, i_RX_Byte, i_Data_Ready,
    input  o_Data, o_Data_Valid, o_Data_Last, o_Busy,
           o_Err_Length, o_Err_Checksum, o_Err_Timeout, o_Err_Overrun
  );

endinterface
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// uart_frame_buf : DEPTH x 8 register file, sync write, async read, no reset
// Rev 1.0
// ============================================================================
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic          i_Clock,
  input  wire logic          i_We,
  input  wire logic [AW-1:0] i_Waddr,
  input  wire logic [7:0]    i_Wdata,
  input  wire logic [AW-1:0] i_Raddr,
  output logic      [7:0]    o_Rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge i_Clock) begin
    if (i_We) begin
      mem_q[i_Waddr] <= i_Wdata;
    end
  end

  assign o_Rdata = mem_q[i_Raddr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// uart_frame_parser : SYNC, LEN, payload, CHK framing with checksum-gated drain
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         MAX_LEN      = MAX_LEN_DEFAULT,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BITS = 20
) (
  input  wire logic          i_Clock,
  input  wire logic          i_Reset,
  uart_frame_parser_if.slave bus
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || CLKS_PER_BIT * TIMEOUT_BITS < 2) begin : g_bad_cfg
    $error("uart_frame_parser: illegal parameter set");
  end

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] wr_idx_q, wr_idx_d;
  logic [7:0] rd_idx_q, rd_idx_d;
  logic       err_len_q, err_len_d;
  logic       err_chk_q, err_chk_d;
  logic       err_ovr_q, err_ovr_d;
  logic       buf_we;
  logic [7:0] buf_rdata;
  logic [7:0] sum_next;
  logic       timer_expire;

  // 8-bit sum so the checksum test wraps mod 256
  assign sum_next = sum_q + bus.i_RX_Byte;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    buf_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_RX_Done && bus.i_RX_Byte == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (bus.i_RX_Done) begin
          if (bus.i_RX_Byte == 8'd0 || bus.i_RX_Byte > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d    = bus.i_RX_Byte;
            sum_d    = bus.i_RX_Byte;
            wr_idx_d = 8'd0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bus.i_RX_Done) begin
          buf_we   = 1'b1;
          sum_d    = sum_next;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == len_q - 8'd1) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.i_RX_Done) begin
          if (sum_next == 8'd0) begin
            rd_idx_d = 8'd0;
            state_d  = ST_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        err_ovr_d = bus.i_RX_Done;
        if (bus.i_Data_Ready) begin
          rd_idx_d = rd_idx_q + 8'd1;
          if (rd_idx_q == len_q - 8'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // expiry is only raised on strobe-free cycles, so it never collides with the above
    if (timer_expire) state_d = ST_IDLE;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      wr_idx_q  <= 8'd0;
      rd_idx_q  <= 8'd0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = CLKS_PER_BIT * TIMEOUT_BITS;
  localparam int GAP_W          = $clog2(TIMEOUT_CYCLES);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_to_q, err_to_d;
  logic             gap_run;

  // every entry into a timed state happens on a strobe, which already clears the count
  always_comb begin
    gap_run      = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    timer_expire = gap_run && !bus.i_RX_Done && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
    gap_d        = (gap_run && !bus.i_RX_Done) ? gap_q + 1'b1 : '0;
    err_to_d     = timer_expire;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      gap_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      err_to_q <= err_to_d;
    end
  end

  assign bus.o_Err_Timeout = err_to_q;
`else
  assign timer_expire      = 1'b0;
  assign bus.o_Err_Timeout = 1'b0;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_Clock (i_Clock),
    .i_We    (buf_we),
    .i_Waddr (wr_idx_q[AW-1:0]),
    .i_Wdata (bus.i_RX_Byte),
    .i_Raddr (rd_idx_q[AW-1:0]),
    .o_Rdata (buf_rdata)
  );

  // data is forced to zero outside DRAIN so un-reset buffer contents never leak out
  assign bus.o_Data_Valid   = (state_q == ST_DRAIN);
  assign bus.o_Data         = (state_q == ST_DRAIN) ? buf_rdata : 8'h00;
  assign bus.o_Data_Last    = (state_q == ST_DRAIN) && (rd_idx_q == len_q - 8'd1);
  assign bus.o_Busy         = (state_q != ST_IDLE);
  assign bus.o_Err_Length   = err_len_q;
  assign bus.o_Err_Checksum = err_chk_q;
  assign bus.o_Err_Overrun  = err_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// tb_uart_frame_parser : directed and random frames against a frame-level model
// Rev 1.0
// ============================================================================
module tb_uart_frame_parser;
  import uart_pkg::*;

  localparam int         MAXL = 16;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         E_LEN = 1, E_CHK = 2, E_TO = 3, E_OVR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .CLKS_PER_BIT (868),
    .MAX_LEN      (MAXL),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_BITS (20)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_data[$];
  int         exp_err[$];
  bit         mon_en     = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_Done = 1'b1;
    bus.i_RX_Byte = b;
    step();
    bus.i_RX_Done = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (bus.o_Busy && c < bound) begin
      step();
      c++;
    end
    check("drain_done_busy", int'(bus.o_Busy), 0);
  endtask

  // frame-level model: the checksum byte is whatever brings LEN+payload+CHK to 0 mod 256
  function automatic logic [7:0] chk_of(input int len, input logic [7:0] pl[$]);
    int s = len;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic push_good(input logic [7:0] pl[$]);
    foreach (pl[i]) exp_data.push_back({(i == pl.size() - 1), pl[i]});
  endtask

  task automatic random_frame();
    logic [7:0] fr[$];
    logic [7:0] pl[$];
    logic [7:0] b;
    int kind, len, nj;
    nj = $urandom_range(0, 2);
    for (int j = 0; j < nj; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      send_byte(b);
      idle($urandom_range(0, 2));
    end
    kind = $urandom_range(0, 3);
    if (kind == 3) begin
      b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
      fr = {SYNC, b};
      exp_err.push_back(E_LEN);
    end else begin
      len = $urandom_range(1, MAXL);
      for (int j = 0; j < len; j++) pl.push_back(8'($urandom_range(0, 255)));
      b = chk_of(len, pl);
      if (kind == 2) begin
        b = b + 8'($urandom_range(1, 255));
        exp_err.push_back(E_CHK);
      end else begin
        push_good(pl);
      end
      fr = {SYNC, 8'(len)};
      foreach (pl[j]) fr.push_back(pl[j]);
      fr.push_back(b);
    end
    send_seq(fr, 2);
    wait_idle(4000);
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.i_Data_Ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor / scoreboard
  initial begin
    logic [8:0] e;
    logic [3:0] errs;
    int         got_e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.o_Data_Valid && bus.i_Data_Ready) begin
          n_tests++;
          if (exp_data.size() == 0) begin
            n_fail++;
            $display("FAIL data_unexpected: got last=%0d data=%h, required no output",
                     bus.o_Data_Last, bus.o_Data);
          end else begin
            e = exp_data.pop_front();
            if ({bus.o_Data_Last, bus.o_Data} != e) begin
              n_fail++;
              $display("FAIL data: got last=%0d data=%h, required last=%0d data=%h",
                       bus.o_Data_Last, bus.o_Data, e[8], e[7:0]);
            end
          end
        end
        errs = {bus.o_Err_Length, bus.o_Err_Checksum, bus.o_Err_Timeout, bus.o_Err_Overrun};
        if (errs != 4'b0000) begin
          check("err_onehot", $countones(errs), 1);
          got_e = errs[3] ? E_LEN : errs[2] ? E_CHK : errs[1] ? E_TO : E_OVR;
          if (exp_err.size() == 0) check("err_unexpected", got_e, 0);
          else check("err_kind", got_e, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    int cnt;
    int vcnt;
    bit seen;
    logic [7:0] pl[$];
    bus.i_RX_Done    = 1'b0;
    bus.i_RX_Byte    = 8'h00;
    bus.i_Data_Ready = 1'b1;
    rst = 1'b1;
    idle(3);
    check("rst_busy",  int'(bus.o_Busy), 0);
    check("rst_valid", int'(bus.o_Data_Valid), 0);
    check("rst_data",  int'(bus.o_Data), 0);
    check("rst_last",  int'(bus.o_Data_Last), 0);
    check("rst_errs",  int'({bus.o_Err_Length, bus.o_Err_Checksum, bus.o_Err_Timeout,
                             bus.o_Err_Overrun}), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // good frame, ready high: three consecutive beats
    pl = {8'h11, 8'h22, 8'h33};
    push_good(pl);
    send_seq({SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
    cnt = 0;
    vcnt = 0;
    while (bus.o_Busy && cnt < 40) begin
      if (bus.o_Data_Valid) vcnt++;
      step();
      cnt++;
    end
    check("drain_cycles", cnt, 3);
    check("drain_valid_cycles", vcnt, 3);

    // bad checksum
    exp_err.push_back(E_CHK);
    send_seq({SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98}, 0);
    check("chk_busy_drop", int'(bus.o_Busy), 0);
    idle(2);

    // illegal lengths, then a single-byte frame
    exp_err.push_back(E_LEN);
    exp_err.push_back(E_LEN);
    send_seq({SYNC, 8'h00, SYNC, 8'h11}, 1);
    pl = {8'h5A};
    push_good(pl);
    send_seq({SYNC, 8'h01, 8'h5A, 8'hA5}, 0);
    wait_idle(100);

    // backpressure with an overrun strobe in the hold window
    bus.i_Data_Ready = 1'b0;
    pl = {8'h11, 8'h22, 8'h33};
    push_good(pl);
    exp_err.push_back(E_OVR);
    send_seq({SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", int'(bus.o_Data_Valid), 1);
      check("hold_data",  int'(bus.o_Data), 'h11);
      check("hold_last",  int'(bus.o_Data_Last), 0);
      if (i == 2) send_byte(8'h5C);
      else idle(1);
    end
    bus.i_Data_Ready = 1'b1;
    wait_idle(100);

    // random frames with random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) random_frame();
    rand_ready = 1'b0;
    bus.i_Data_Ready = 1'b1;
    idle(2);

`ifdef UART_FRAME_TIMEOUT_EN
    exp_err.push_back(E_TO);
    send_seq({SYNC, 8'h03, 8'h11}, 0);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 20000) begin
      step();
      cnt++;
      if (bus.o_Err_Timeout) seen = 1'b1;
    end
    check("timeout_latency", cnt, 17360);
    check("timeout_busy", int'(bus.o_Busy), 0);
    pl = {8'h5A};
    push_good(pl);
    send_seq({SYNC, 8'h01, 8'h5A, 8'hA5}, 0);
    wait_idle(100);
`endif

    // reset mid-payload; the tail of the frame must be ignored
    send_seq({SYNC, 8'h03, 8'h11}, 0);
    rst = 1'b1;
    step();
    check("midrst_busy",  int'(bus.o_Busy), 0);
    check("midrst_valid", int'(bus.o_Data_Valid), 0);
    check("midrst_data",  int'(bus.o_Data), 0);
    check("midrst_errs",  int'({bus.o_Err_Length, bus.o_Err_Checksum, bus.o_Err_Timeout,
                                bus.o_Err_Overrun}), 0);
    rst = 1'b0;
    send_seq({8'h22, 8'h33, 8'h97}, 1);
    idle(3);
    check("tail_ignored_busy", int'(bus.o_Busy), 0);

    idle(5);
    check("left_data", exp_data.size(), 0);
    check("left_err",  exp_err.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
